// File: rtl/cache_pmem_arbiter.sv
// Arbitrates one burst pmem port between the icache and dcache, one line transaction at a time.
// Optional macro ARB_RR_EN: round-robin tie-break instead of fixed dcache priority.
module cache_pmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_addr,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_RD, D_WR} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [LINE_WIDTH-1:0] wdata_reg;
  logic [LINE_WIDTH-1:0] i_hold_reg;
  logic [LINE_WIDTH-1:0] d_hold_reg;
  logic                  pmem_read_reg;
  logic                  pmem_write_reg;
  logic                  d_req;
  logic                  pick_d;

  assign d_req = d_read | d_write;

`ifdef ARB_RR_EN
  logic rr_last;
  // On a tie the cache not granted last wins; rr_last=0 lets the dcache take the first tie.
  assign pick_d = d_req & (~i_read | ~rr_last);
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      i_hold_reg     <= '0;
      d_hold_reg     <= '0;
      pmem_read_reg  <= 1'b0;
      pmem_write_reg <= 1'b0;
`ifdef ARB_RR_EN
      rr_last        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            // d_read with d_write is illegal; the write takes precedence.
            state          <= d_write ? D_WR : D_RD;
            addr_reg       <= d_addr;
            pmem_read_reg  <= ~d_write;
            pmem_write_reg <= d_write;
            if (d_write) wdata_reg <= d_wdata;
`ifdef ARB_RR_EN
            rr_last        <= 1'b1;
`endif
          end else if (i_read) begin
            state         <= I_BUSY;
            addr_reg      <= i_addr;
            pmem_read_reg <= 1'b1;
`ifdef ARB_RR_EN
            rr_last       <= 1'b0;
`endif
          end
        end
        default: begin
          if (pmem_resp) begin
            state          <= IDLE;
            pmem_read_reg  <= 1'b0;
            pmem_write_reg <= 1'b0;
            if (state == I_BUSY) i_hold_reg <= pmem_rdata;
            if (state == D_RD)   d_hold_reg <= pmem_rdata;
          end
        end
      endcase
    end
  end

  assign pmem_read  = pmem_read_reg;
  assign pmem_write = pmem_write_reg;
  assign pmem_addr  = (state != IDLE) ? addr_reg : '0;
  assign pmem_wdata = (state == D_WR) ? wdata_reg : '0;

  // Owner sees memory data live; the other side keeps the last line it received.
  assign i_rdata = (state == I_BUSY) ? pmem_rdata : i_hold_reg;
  assign d_rdata = (state == D_RD)   ? pmem_rdata : d_hold_reg;
  assign i_resp  = (state == I_BUSY) & pmem_resp;
  assign d_resp  = ((state == D_RD) | (state == D_WR)) & pmem_resp;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst && state == IDLE)
      assert (!(d_read && d_write))
        else $warning("illegal simultaneous d_read and d_write, treated as write");
  end
`endif

endmodule

// File: tb/tb_cache_pmem_arbiter.sv
// Directed bench for cache_pmem_arbiter; expected tie order follows ARB_RR_EN when defined.
module tb_cache_pmem_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write, pmem_resp;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] d_wdata, pmem_rdata;
  logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
  logic          i_resp, d_resp, pmem_read, pmem_write;
  logic [AW-1:0] pmem_addr;

  int checks = 0;
  int errors = 0;

  cache_pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000", {pmem_read, pmem_write, i_resp, d_resp});
    end
    checks++;
    if (pmem_addr !== '0 || pmem_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
      errors++;
      $display("FAIL reset_data got addr %h wdata %h want 0", pmem_addr, pmem_wdata);
    end
    tick();
    rst = 1'b1;
    tick();
    $display("reset done");
  endtask

  task automatic test_tie();
    logic exp_d [4];
    logic [7:0] b;
`ifdef ARB_RR_EN
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif
    i_addr = 32'h0000_1000; d_addr = 32'h0000_2000;
    i_read = 1'b1; d_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) d_read = 1'b0;
      checks++;
      if (pmem_read !== 1'b0) begin
        errors++;
        $display("FAIL tie_idle[%0d] got pmem_read %b want 0", k, pmem_read);
      end
      tick();
      checks++;
      if (pmem_read !== 1'b1 || pmem_addr !== (exp_d[k] ? 32'h0000_2000 : 32'h0000_1000)) begin
        errors++;
        $display("FAIL tie_grant[%0d] got read %b addr %h want dcache %b", k, pmem_read, pmem_addr, exp_d[k]);
      end
      if (k == 0) begin
        checks++;
        if (i_rdata !== '0) begin
          errors++;
          $display("FAIL tie_hold got i_rdata %h want 0", i_rdata);
        end
      end
      b = 8'(k + 1);
      pmem_rdata = {32{b}};
      pmem_resp = 1'b1;
      #1;
      checks++;
      if (d_resp !== exp_d[k] || i_resp !== !exp_d[k]) begin
        errors++;
        $display("FAIL tie_resp[%0d] got i %b d %b want d %b", k, i_resp, d_resp, exp_d[k]);
      end
      $display("tie %0d granted %s", k, d_resp ? "dcache" : "icache");
      tick();
      pmem_resp = 1'b0;
    end
    i_read = 1'b0;
  endtask

  task automatic test_icache_fill();
    i_read = 1'b1; i_addr = 32'h0000_0060;
    tick();
    checks++;
    if (pmem_read !== 1'b1 || pmem_addr !== 32'h0000_0060) begin
      errors++;
      $display("FAIL fill_start got read %b addr %h want 1 00000060", pmem_read, pmem_addr);
    end
    tick(); tick(); tick();
    pmem_rdata = {32{8'hA5}};
    pmem_resp = 1'b1;
    #1;
    checks++;
    if (i_resp !== 1'b1 || i_rdata !== {32{8'hA5}} || d_resp !== 1'b0) begin
      errors++;
      $display("FAIL fill_resp got i_resp %b d_resp %b i_rdata %h want 1 0 a5..", i_resp, d_resp, i_rdata);
    end
    checks++;
    if (d_rdata !== {32{8'h03}}) begin
      errors++;
      $display("FAIL fill_d_hold got %h want 03..", d_rdata);
    end
    tick();
    i_read = 1'b0; pmem_resp = 1'b0; pmem_rdata = '0;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || i_resp !== 1'b0 || i_rdata !== {32{8'hA5}} || pmem_addr !== '0) begin
      errors++;
      $display("FAIL fill_end got read %b resp %b rdata %h addr %h", pmem_read, i_resp, i_rdata, pmem_addr);
    end
    $display("icache fill done");
  endtask

  task automatic test_writeback();
    int pulses = 0;
    d_write = 1'b1; d_addr = 32'h8000_0100; d_wdata = {8{32'h1234_5678}};
    tick();
    d_wdata = {8{32'hDEAD_BEEF}};
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_addr !== 32'h8000_0100 ||
          pmem_wdata !== {8{32'h1234_5678}}) begin
        errors++;
        $display("FAIL wb_burst[%0d] got w %b r %b addr %h wdata %h", c, pmem_write, pmem_read, pmem_addr, pmem_wdata);
      end
      if (d_resp) pulses++;
      tick();
    end
    pmem_resp = 1'b1;
    #1;
    if (d_resp) pulses++;
    checks++;
    if (i_resp !== 1'b0 || pmem_read !== 1'b0) begin
      errors++;
      $display("FAIL wb_other got i_resp %b pmem_read %b want 0 0", i_resp, pmem_read);
    end
    tick();
    pmem_resp = 1'b0; d_write = 1'b0;
    #1;
    if (d_resp) pulses++;
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL wb_pulses got %0d want 1", pulses);
    end
    checks++;
    if (pmem_write !== 1'b0 || pmem_addr !== '0 || pmem_wdata !== '0) begin
      errors++;
      $display("FAIL wb_end got w %b addr %h wdata %h want 0", pmem_write, pmem_addr, pmem_wdata);
    end
    $display("dcache writeback done");
  endtask

  task automatic test_reset_mid_burst();
    i_read = 1'b1; i_addr = 32'h0000_0060;
    tick(); tick();
    #2;
    rst = 1'b0; pmem_resp = 1'b1; pmem_rdata = {32{8'h5A}};
    #1;
    checks++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0 || pmem_addr !== '0 || i_rdata !== '0) begin
      errors++;
      $display("FAIL rst_async got r %b resp %b addr %h rdata %h want 0", pmem_read, i_resp, pmem_addr, i_rdata);
    end
    i_read = 1'b0; pmem_resp = 1'b0;
    #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || pmem_addr !== '0) begin
        errors++;
        $display("FAIL rst_idle[%0d] got r %b w %b addr %h want 0", c, pmem_read, pmem_write, pmem_addr);
      end
    end
    $display("reset mid burst done");
  endtask

  task automatic test_stray_and_illegal();
    pmem_resp = 1'b1;
    #1;
    checks++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
      errors++;
      $display("FAIL stray_resp got i %b d %b want 0 0", i_resp, d_resp);
    end
    tick();
    pmem_resp = 1'b0;
    checks++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      errors++;
      $display("FAIL stray_grant got r %b w %b want 0 0", pmem_read, pmem_write);
    end
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h0000_0300; d_wdata = {8{32'hCAFE_F00D}};
    tick();
    checks++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_wdata !== {8{32'hCAFE_F00D}}) begin
      errors++;
      $display("FAIL illegal_wr got w %b r %b wdata %h", pmem_write, pmem_read, pmem_wdata);
    end
    pmem_resp = 1'b1;
    #1;
    checks++;
    if (d_resp !== 1'b1) begin
      errors++;
      $display("FAIL illegal_resp got %b want 1", d_resp);
    end
    tick();
    pmem_resp = 1'b0; d_read = 1'b0; d_write = 1'b0;
    #1;
    $display("stray resp and illegal pair done");
  endtask

  initial begin
    rst = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; pmem_rdata = '0;
    test_reset();
    test_tie();
    test_icache_fill();
    test_writeback();
    test_reset_mid_burst();
    test_stray_and_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_pmem_arbiter.md
Name: cache_pmem_arbiter

Overview:
- Shares the single burst physical-memory port (pmem_*) between the L1 instruction cache and the L1 data cache.
- Sits inside mp4, between the two caches and the top-level pmem ports.
- Grants one cache line transaction at a time.
- Latches the winner's address and write data, and routes pmem_rdata/pmem_resp back to the owner.

Parameters:
- ADDR_WIDTH, 32, physical address width.
- LINE_WIDTH, 256, cache line width in bits (one pmem burst).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_read  in  1  icache line-fill request; held high until i_resp.
- i_addr  in  ADDR_WIDTH  icache line address.
- i_rdata  out  LINE_WIDTH  fill data to icache.
- i_resp  out  1  icache transaction done (1-cycle pulse).
- d_read  in  1  dcache line-fill request; held until d_resp.
- d_write  in  1  dcache writeback request; held until d_resp.
- d_addr  in  ADDR_WIDTH  dcache line address.
- d_wdata  in  LINE_WIDTH  dcache writeback line.
- d_rdata  out  LINE_WIDTH  fill data to dcache.
- d_resp  out  1  dcache transaction done (1-cycle pulse).
- pmem_read  out  1  burst read to memory.
- pmem_write  out  1  burst write to memory.
- pmem_addr  out  ADDR_WIDTH  burst address.
- pmem_wdata  out  LINE_WIDTH  burst write line.
- pmem_rdata  in  LINE_WIDTH  burst read line.
- pmem_resp  in  1  burst complete.

Behaviour:
- States: IDLE, I_BUSY, D_RD, D_WR. Reset state is IDLE.
- Reset (rst=0, asynchronous):
  - State goes to IDLE; latched addr/wdata and the rr_last flag clear to 0.
  - All outputs go to 0 immediately, including mid-burst. The in-flight transaction is abandoned and no resp is issued.
- IDLE:
  - pmem_read = pmem_write = 0, i_resp = d_resp = 0.
  - At the edge, sample requests and pick the winner:
    - d_write alone -> D_WR.
    - d_read alone -> D_RD.
    - i_read alone -> I_BUSY.
    - dcache and icache both requesting -> dcache wins (fixed priority; see Optional Feature).
  - On grant, latch the winner's address into the addr register; for D_WR also latch d_wdata.
- d_read and d_write both high is illegal. Arbiter treats it as D_WR and raises an assertion in simulation.
- I_BUSY / D_RD:
  - pmem_read = 1; pmem_addr = latched address.
  - Owner's rdata = pmem_rdata combinationally.
  - The non-owner's rdata holds its last value; its resp stays 0.
- D_WR:
  - pmem_write = 1; pmem_addr and pmem_wdata come from the latches.
- Completion:
  - In any BUSY state, pmem_resp=1 drives the owner's resp=1 in the same cycle; state returns to IDLE at that edge.
  - The mandatory IDLE cycle after each transaction lets the cache drop or replace its request before re-arbitration.
  - Minimum latency: request to pmem_read is 1 cycle; pmem_resp to the owner's resp is 0 cycles.
- pmem_resp while in IDLE is ignored; no resp is generated.
- Requests deasserted mid-transaction are ignored. The grant holds until pmem_resp.
- Back-to-back throughput: one transaction per (burst latency + 1 IDLE cycle).
- pmem_addr/pmem_wdata are 0 in IDLE.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined:
  - A rr_last flag records the last granted cache (0=icache, 1=dcache).
  - On a simultaneous icache+dcache request, the cache not granted last wins.
  - rr_last updates at each grant and resets to 0, so the dcache wins the first tie.
- Undefined: fixed dcache priority; rr_last is not instantiated.

Test Plan:
- Single icache fill: i_read=1, i_addr=0x0000_0060; memory responds after 4 cycles with line 0xA5..A5.
  - pmem_read=1 and pmem_addr=0x60 from cycle 1.
  - i_resp=1 and i_rdata=0xA5..A5 on the pmem_resp cycle.
  - d_resp stays 0.
- Dcache writeback: d_write=1, d_addr=0x8000_0100, d_wdata=0x1234...
  - pmem_write=1 with latched addr/data, even if d_wdata changes mid-burst.
  - d_resp pulses once; pmem_read stays 0.
- Simultaneous i_read and d_read, macro undefined:
  - The dcache is served first, then IDLE for one cycle, then the icache.
  - Repeated ties never grant the icache first.
- Simultaneous requests with ARB_RR_EN, three back-to-back ties:
  - Grant order is D, I, D.
  - Each grant is separated by exactly one IDLE cycle.
- Reset mid-burst: assert rst=0 two cycles into an I_BUSY burst.
  - pmem_read, i_resp and all outputs drop to 0 asynchronously, before the next edge.
  - After release with no requests, the arbiter stays in IDLE.
- Stray pmem_resp=1 in IDLE, and d_read and d_write both high:
  - The stray pmem_resp produces no resp.
  - The illegal pair is treated as a write and fires the assertion.
